// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster timing generator with a per-frame tear-free scroll offset
module vga_scan_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCROLL_WRAP = 640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       scroll_en,
    input  logic [3:0] scroll_step,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       vblank,
    output logic       frame_start,
    output logic       line_start,
    output logic [9:0] scroll_offset
);
    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] WRAP   = 11'(SCROLL_WRAP);

    logic [9:0]  sx_n;
    logic [9:0]  sy_n;
    logic [10:0] sum;
    logic        upd;

    // next raster position and the once-per-frame scroll update point (0, V_ACTIVE)
    always_comb begin
        sx_n = (sx == H_LAST) ? '0 : sx + 10'd1;
        sy_n = (sx != H_LAST) ? sy : (sy == V_LAST) ? '0 : sy + 10'd1;
        upd  = scroll_en && sx_n == '0 && sy_n == V_VIS;
        sum  = {1'b0, scroll_offset} + {7'd0, scroll_step};
    end

    // counters and sync/enable flags load together so they never skew; pulses clear on idle clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx            <= H_LAST;
            sy            <= V_LAST;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            de            <= 1'b0;
            vblank        <= 1'b1;
            frame_start   <= 1'b0;
            line_start    <= 1'b0;
            scroll_offset <= '0;
        end else begin
            frame_start <= pix_en && sx_n == '0 && sy_n == '0;
            line_start  <= pix_en && sx_n == '0;
            if (pix_en) begin
                sx     <= sx_n;
                sy     <= sy_n;
                hsync  <= !(sx_n >= HS_BEG && sx_n < HS_END);
                vsync  <= !(sy_n >= VS_BEG && sy_n < VS_END);
                de     <= sx_n < H_VIS && sy_n < V_VIS;
                vblank <= sy_n >= V_VIS;
                if (upd)
                    scroll_offset <= (sum >= WRAP) ? 10'(sum - WRAP) : sum[9:0];
            end
        end
    end
endmodule
